dm_abstract_cmd: RTL

Debug Module abstract-command engine. Accepts Access Register commands written by the debug transport (DMI) side, checks them, and turns each into one register access on the hart-side Debug CSR port (`dm_reg_rd_wr_*`). Holds the `data0` argument register, `busy` and `cmderr`. Sits directly upstream of the CSR block and drives its DM access port.

---
 rtl/dm_pkg.sv | 31 +++
 rtl/dm_cmd_check.sv | 55 +++++
 rtl/dm_abstract_cmd.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and command field layout for the debug abstract-command engine
package dm_pkg;

    localparam int CMD_CMDTYPE_MSB = 31;
    localparam int CMD_CMDTYPE_LSB = 24;
    localparam int CMD_AARSIZE_MSB = 22;
    localparam int CMD_AARSIZE_LSB = 20;
    localparam int CMD_TRANSFER_BIT = 17;
    localparam int CMD_WRITE_BIT = 16;
    localparam int CMD_REGNO_MSB = 15;
    localparam int CMD_REGNO_LSB = 0;

    localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'h00;
    localparam logic [2:0] AARSIZE_32 = 3'd2;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPTION  = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cmd_state_e;

endpackage

// File: rtl/dm_cmd_check.sv
// rtl/dm_cmd_check.sv - combinational decode and priority check of an Access Register command
import dm_pkg::*;

module dm_cmd_check #(
    parameter logic [15:0] REGNO_MAX = 16'h0FFF
) (
    input  logic [31:0] i_cmd,
    input  logic        i_halted,
    input  cmderr_e     i_cmderr,
    output logic        o_accept,
    output logic        o_noaccess,
    output logic        o_set_err,
    output cmderr_e     o_err
);

    logic [7:0]  w_cmdtype;
    logic [2:0]  w_aarsize;
    logic        w_transfer;
    logic [15:0] w_regno;
    logic        w_unused_bits;

    assign w_cmdtype     = i_cmd[CMD_CMDTYPE_MSB:CMD_CMDTYPE_LSB];
    assign w_aarsize     = i_cmd[CMD_AARSIZE_MSB:CMD_AARSIZE_LSB];
    assign w_transfer    = i_cmd[CMD_TRANSFER_BIT];
    assign w_regno       = i_cmd[CMD_REGNO_MSB:CMD_REGNO_LSB];
    assign w_unused_bits = ^{i_cmd[23], i_cmd[19:18], i_cmd[CMD_WRITE_BIT]};

    // A pending error silences every check: the command is simply dropped.
    always_comb begin
        o_accept   = 1'b0;
        o_noaccess = 1'b0;
        o_set_err  = 1'b0;
        o_err      = CMDERR_NONE;
        if (i_cmderr == CMDERR_NONE) begin
            if (w_cmdtype != CMDTYPE_ACCESS_REG) begin
                o_set_err = 1'b1;
                o_err     = CMDERR_NOTSUP;
            end else if (w_transfer && (w_aarsize != AARSIZE_32)) begin
                o_set_err = 1'b1;
                o_err     = CMDERR_NOTSUP;
            end else if (!i_halted) begin
                o_set_err = 1'b1;
                o_err     = CMDERR_HALTRESUME;
            end else if (w_transfer && (w_regno > REGNO_MAX)) begin
                o_set_err = 1'b1;
                o_err     = CMDERR_EXCEPTION;
            end else if (!w_transfer) begin
                o_noaccess = 1'b1;
            end else begin
                o_accept = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_abstract_cmd.sv
// rtl/dm_abstract_cmd.sv - abstract-command engine driving the hart Debug CSR port; DM_AUTOEXEC_EN adds autoexec
import dm_pkg::*;

module dm_abstract_cmd #(
    parameter logic [15:0] REGNO_MAX = 16'h0FFF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        hart_halted_i,
    input  logic        dmi_cmd_valid_i,
    input  logic [31:0] dmi_cmd_i,
    input  logic        dmi_data0_wr_i,
    input  logic [31:0] dmi_data0_wdata_i,
    input  logic        dmi_data0_rd_i,
    input  logic        dmi_autoexec_i,
    input  logic [2:0]  dmi_cmderr_clr_i,
    output logic [31:0] data0_o,
    output logic        busy_o,
    output logic [2:0]  cmderr_o,
    output logic        dm_reg_rd_wr_en_o,
    output logic        dm_reg_rd_wr_o,
    output logic [15:0] dm_reg_rd_wr_address_o,
    inout  wire  [31:0] dm_reg_rd_wr_data_io
);

    cmd_state_e  r_state;
    cmd_state_e  w_state_next;
    logic [31:0] r_data0;
    cmderr_e     r_cmderr;
    cmderr_e     w_cmderr_next;
    logic        r_write;
    logic [15:0] r_regno;

    logic        w_idle;
    logic        w_cmd_go;
    logic [31:0] w_cmd_word;
    logic        w_data0_rd;
    logic        w_chk_accept;
    logic        w_chk_noaccess;
    logic        w_chk_set_err;
    cmderr_e     w_chk_err;
    logic        w_accept;
    logic        w_noaccess;
    logic        w_busy_viol;
    logic        w_en;
    logic        w_bus_drive;

    assign w_idle = (r_state == ST_IDLE);

`ifdef DM_AUTOEXEC_EN
    logic [31:0] r_last_cmd;
    logic        w_auto_go;

    assign w_data0_rd = dmi_data0_rd_i;
    assign w_auto_go  = w_idle && (r_cmderr == CMDERR_NONE) && dmi_autoexec_i
                        && (dmi_data0_rd_i || dmi_data0_wr_i);
    assign w_cmd_go   = dmi_cmd_valid_i || w_auto_go;
    assign w_cmd_word = dmi_cmd_valid_i ? dmi_cmd_i : r_last_cmd;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_last_cmd <= '0;
        end else if (w_accept || w_noaccess) begin
            r_last_cmd <= w_cmd_word;
        end
    end
`else
    logic w_unused_auto;

    assign w_data0_rd    = 1'b0;
    assign w_cmd_go      = dmi_cmd_valid_i;
    assign w_cmd_word    = dmi_cmd_i;
    assign w_unused_auto = dmi_autoexec_i ^ dmi_data0_rd_i;
`endif

    dm_cmd_check #(
        .REGNO_MAX (REGNO_MAX)
    ) u_check (
        .i_cmd      (w_cmd_word),
        .i_halted   (hart_halted_i),
        .i_cmderr   (r_cmderr),
        .o_accept   (w_chk_accept),
        .o_noaccess (w_chk_noaccess),
        .o_set_err  (w_chk_set_err),
        .o_err      (w_chk_err)
    );

    assign w_accept    = w_idle && w_cmd_go && w_chk_accept;
    assign w_noaccess  = w_idle && w_cmd_go && w_chk_noaccess;
    assign w_busy_viol = !w_idle && (dmi_cmd_valid_i || dmi_data0_wr_i || w_data0_rd);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_en         = 1'b0;
        w_bus_drive  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_ACCESS;
                end else if (w_noaccess) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_ACCESS: begin
                w_en         = 1'b1;
                w_bus_drive  = r_write;
                w_state_next = r_write ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: w_state_next = ST_DONE;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Clears apply first so that a same-cycle set always survives.
    always_comb begin
        w_cmderr_next = cmderr_e'(r_cmderr & ~dmi_cmderr_clr_i);
        if (w_busy_viol && (r_cmderr == CMDERR_NONE)) begin
            w_cmderr_next = CMDERR_BUSY;
        end else if (w_idle && w_cmd_go && w_chk_set_err) begin
            w_cmderr_next = w_chk_err;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cmderr <= CMDERR_NONE;
            r_data0  <= '0;
            r_write  <= 1'b0;
            r_regno  <= '0;
        end else begin
            r_cmderr <= w_cmderr_next;
            if (r_state == ST_CAPTURE) begin
                r_data0 <= dm_reg_rd_wr_data_io;
            end else if (w_idle && dmi_data0_wr_i) begin
                r_data0 <= dmi_data0_wdata_i;
            end
            if (w_accept) begin
                r_write <= w_cmd_word[CMD_WRITE_BIT];
                r_regno <= w_cmd_word[CMD_REGNO_MSB:CMD_REGNO_LSB];
            end
        end
    end

    assign data0_o                = r_data0;
    assign busy_o                 = !w_idle;
    assign cmderr_o               = r_cmderr;
    assign dm_reg_rd_wr_en_o      = w_en;
    assign dm_reg_rd_wr_o         = w_en && r_write;
    assign dm_reg_rd_wr_address_o = r_regno;
    assign dm_reg_rd_wr_data_io   = w_bus_drive ? r_data0 : 32'bz;

endmodule
